hack_run_controller: RTL and testbench
======================================

Name: hack_run_controller

Overview:
- Parametrised clock-enable and reset sequencer that drives the Hack CPU Computer.
- It replaces fixed, hand-toggled clock sequences with programmable behaviour:
  - reset hold for a set number of cycles,
  - free-run, run-for-N-cycles and single-step modes,
  - a PC breakpoint,
  - an executed-cycle counter.
- Sits between the system clock/reset and the Computer's reset and clock-enable inputs. Usable both in benches and on the board.

Parameters:
- CNT_W, 16, width of run_len, the remaining-cycle counter and cycle_count.
- PC_W, 15, width of the Hack program counter (pc, bp_addr).
- RESET_CYCLES, 4, number of CLK cycles cpu_reset is held high after reset deasserts; must be >= 1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution in the selected mode.
- step  in  1  one-cycle pulse; in step mode, grants exactly one CPU cycle.
- stop  in  1  one-cycle pulse; forces HALT.
- mode  in  2  00 free-run, 01 counted run, 10 single-step, 11 reserved (treated as 00). Sampled only on start.
- run_len  in  CNT_W  cycle budget for counted run. Sampled only on start.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC value.
- pc  in  PC_W  current CPU program counter.
- cpu_reset  out  1  reset to the Computer.
- cpu_ce  out  1  CPU clock enable; one high cycle = one executed instruction.
- busy  out  1  high in RUN or STEP.
- done  out  1  high in HALT.
- cycle_count  out  CNT_W  number of cycles with cpu_ce high, excluding RST_HOLD. Saturates at all-ones.
- halt_cause  out  2  00 none, 01 count expired, 10 stop, 11 breakpoint.

Behaviour:
- States: RST_HOLD, IDLE, RUN, STEP, HALT.
- Reset asserted (async):
  - state = RST_HOLD, hold counter = RESET_CYCLES.
  - cpu_reset = 1, cpu_ce = 1 (the CPU's synchronous reset needs enabled edges).
  - busy = 0, done = 0, cycle_count = 0, halt_cause = 00, remaining = 0.
- RST_HOLD:
  - Decrement the hold counter each cycle after reset deasserts.
  - At 0, go to IDLE; cpu_reset and cpu_ce drop together, so cpu_reset is high for exactly RESET_CYCLES cycles after deassertion.
  - start, step and stop are ignored in this state.
- IDLE / HALT, on start:
  - mode 00: go to RUN, unbounded.
  - mode 01, run_len != 0: go to RUN, remaining = run_len.
  - mode 01, run_len == 0: go to HALT, halt_cause = 01, no cpu_ce cycle.
  - mode 10: go to STEP.
  - Entering any non-HALT state clears halt_cause to 00. cycle_count is kept across HALT; it is cleared only by reset.
- Enable path:
  - cpu_ce = ce_q & ~bp_hit, where bp_hit = bp_en & (pc == bp_addr) & ~bp_mask.
  - ce_q is registered: high from the first cycle after entering RUN, high for one cycle per accepted step in STEP, low otherwise.
  - bp_mask is set for the first enabled cycle after each start or step, so execution can resume from a breakpoint.
- RUN:
  - Each cycle with cpu_ce high: cycle_count++, and remaining-- if counted.
  - Counted run: the cycle where cpu_ce is high with remaining == 1 is the last; next state HALT, halt_cause 01. Exactly run_len ce cycles are issued.
  - bp_hit: cpu_ce is low that cycle (the instruction at bp_addr is not executed); next state HALT, halt_cause 11.
  - stop: next state HALT, halt_cause 10. cpu_ce may still be high in the stop cycle, so latency is 1 cycle.
- STEP:
  - A step pulse sets ce_q for exactly one cycle. A step arriving while that ce cycle is in progress is ignored.
  - stop goes to HALT with cause 10. bp_hit on the granted cycle goes to HALT with cause 11.
- Priority in the same cycle, highest first: reset > stop > breakpoint > count expiry > start/step.
  - bp and count expiry together: cause 11, remaining unchanged, since the instruction did not execute.
  - start while busy is ignored.
- busy and done are decoded from state; registered, with no combinational path from inputs.

Decomposition:
- Package hack_run_pkg holds:
  - state encoding (RST_HOLD, IDLE, RUN, STEP, HALT),
  - mode codes MODE_FREE, MODE_COUNT, MODE_STEP,
  - halt_cause codes CAUSE_NONE, CAUSE_COUNT, CAUSE_STOP, CAUSE_BP.
- One sub-module: hack_sat_counter. CNT_W-wide up counter with enable and async clear that saturates at all-ones; it implements cycle_count.

Test Plan:
- Reset 100 ns, then release, RESET_CYCLES = 4 -> cpu_reset high for exactly 4 rising edges after release; then IDLE with cpu_ce = 0 and cycle_count = 0.
- mode = 01, run_len = 30, start -> exactly 30 cpu_ce cycles; then done = 1, halt_cause = 01, cycle_count = 30. A second start with run_len = 5 -> cycle_count = 35.
- mode = 00, bp_en = 1, bp_addr = 0x000A, CPU running a linear program from PC 0 -> HALT with cpu_ce low while pc = 0x000A, halt_cause = 11, cycle_count = 10. Start again -> pc advances past 0x000A.
- mode = 10, three step pulses spaced 5 cycles apart -> exactly 3 single-cycle cpu_ce pulses, cycle_count = 3. A step in the cycle after a step is ignored.
- mode = 00 run, stop and breakpoint in the same cycle -> halt_cause = 10. Separately, mode = 01 with run_len = 0 -> immediate HALT, cause 01, no cpu_ce.
- Async reset asserted mid-RUN -> cpu_reset = 1 and all counters and outputs return to reset values without waiting for a clock edge; normal reset sequencing resumes after release.

Source files
------------

// File: rtl/hack_run_pkg.sv
// Shared encodings for the Hack run controller: FSM states, start modes and halt causes.
package hack_run_pkg;

    typedef enum logic [2:0] {
        S_RST_HOLD = 3'd0,
        S_IDLE     = 3'd1,
        S_RUN      = 3'd2,
        S_STEP     = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [1:0] MODE_FREE  = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_COUNT = 2'b01;
    localparam logic [1:0] CAUSE_STOP  = 2'b10;
    localparam logic [1:0] CAUSE_BP    = 2'b11;

endpackage

// File: rtl/hack_sat_counter.sv
// Up counter with enable and asynchronous clear that sticks at all-ones instead of wrapping.
module hack_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hack_run_controller.sv
// Clock-enable and reset sequencer for the Hack Computer: reset hold, free/counted/step
// execution, PC breakpoint and a saturating executed-cycle counter.
module hack_run_controller
    import hack_run_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int PC_W         = 15,
    parameter int RESET_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] run_len,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_reset,
    output logic             cpu_ce,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       halt_cause
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    state_t            r_state, w_state_n;
    logic [HOLD_W-1:0] r_hold, w_hold_n;
    logic              r_ce_q, w_ce_n;
    logic              r_bp_mask, w_mask_n;
    logic              r_counted, w_counted_n;
    logic [CNT_W-1:0]  r_rem, w_rem_n;
    logic [1:0]        r_cause, w_cause_n;
    logic [1:0]        w_mode_eff;
    logic              w_busy, w_bp_hit, w_ce, w_last;

    // Breakpoint only matters on a cycle that would otherwise execute; the mask lets the
    // instruction sitting at bp_addr run once after a start or step.
    assign w_busy   = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_bp_hit = bp_en && (pc == bp_addr) && !r_bp_mask && r_ce_q && w_busy;
    assign w_ce     = r_ce_q && !w_bp_hit;
    assign w_last   = w_ce && r_counted && (r_rem == CNT_W'(1));

    assign w_mode_eff = ((mode == MODE_COUNT) || (mode == MODE_STEP)) ? mode : MODE_FREE;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= S_RST_HOLD;
            r_hold    <= HOLD_W'(RESET_CYCLES);
            r_ce_q    <= 1'b1;
            r_bp_mask <= 1'b0;
            r_counted <= 1'b0;
            r_rem     <= '0;
            r_cause   <= CAUSE_NONE;
        end else begin
            r_state   <= w_state_n;
            r_hold    <= w_hold_n;
            r_ce_q    <= w_ce_n;
            r_bp_mask <= w_mask_n;
            r_counted <= w_counted_n;
            r_rem     <= w_rem_n;
            r_cause   <= w_cause_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_hold_n    = r_hold;
        w_ce_n      = r_ce_q;
        w_mask_n    = r_bp_mask;
        w_counted_n = r_counted;
        w_rem_n     = r_rem;
        w_cause_n   = r_cause;

        case (r_state)
            S_RST_HOLD: begin
                if (r_hold <= HOLD_W'(1)) begin
                    w_state_n = S_IDLE;
                    w_hold_n  = '0;
                    w_ce_n    = 1'b0;
                end else begin
                    w_hold_n = r_hold - HOLD_W'(1);
                end
            end

            S_IDLE, S_HALT: begin
                if (stop) begin
                    w_state_n = S_HALT;
                    w_cause_n = CAUSE_STOP;
                    w_ce_n    = 1'b0;
                end else if (start) begin
                    w_mask_n  = 1'b1;
                    w_cause_n = CAUSE_NONE;
                    case (w_mode_eff)
                        MODE_COUNT: begin
                            w_counted_n = 1'b1;
                            w_rem_n     = run_len;
                            if (run_len == '0) begin
                                w_state_n = S_HALT;
                                w_cause_n = CAUSE_COUNT;
                                w_ce_n    = 1'b0;
                            end else begin
                                w_state_n = S_RUN;
                                w_ce_n    = 1'b1;
                            end
                        end
                        MODE_STEP: begin
                            w_state_n   = S_STEP;
                            w_counted_n = 1'b0;
                            w_ce_n      = 1'b0;
                        end
                        MODE_FREE: begin
                            w_state_n   = S_RUN;
                            w_counted_n = 1'b0;
                            w_ce_n      = 1'b1;
                        end
                        default: begin
                            w_state_n = r_state;
                        end
                    endcase
                end
            end

            S_RUN: begin
                if (r_ce_q) w_mask_n = 1'b0;
                if (w_ce && r_counted) w_rem_n = r_rem - CNT_W'(1);
                if (stop) begin
                    w_state_n = S_HALT;
                    w_cause_n = CAUSE_STOP;
                    w_ce_n    = 1'b0;
                end else if (w_bp_hit) begin
                    w_state_n = S_HALT;
                    w_cause_n = CAUSE_BP;
                    w_ce_n    = 1'b0;
                end else if (w_last) begin
                    w_state_n = S_HALT;
                    w_cause_n = CAUSE_COUNT;
                    w_ce_n    = 1'b0;
                end
            end

            S_STEP: begin
                // A granted cycle lasts exactly one clock; steps arriving during it are dropped.
                if (r_ce_q) begin
                    w_ce_n   = 1'b0;
                    w_mask_n = 1'b0;
                end
                if (stop) begin
                    w_state_n = S_HALT;
                    w_cause_n = CAUSE_STOP;
                    w_ce_n    = 1'b0;
                end else if (w_bp_hit) begin
                    w_state_n = S_HALT;
                    w_cause_n = CAUSE_BP;
                    w_ce_n    = 1'b0;
                end else if (step && !r_ce_q) begin
                    w_ce_n   = 1'b1;
                    w_mask_n = 1'b1;
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_ce_n    = 1'b0;
            end
        endcase
    end

    hack_sat_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_cnt (
        .i_clk  (CLK),
        .i_clr  (reset),
        .i_en   (w_ce && w_busy),
        .o_count(cycle_count)
    );

    assign cpu_reset  = (r_state == S_RST_HOLD);
    assign cpu_ce     = w_ce;
    assign busy       = w_busy;
    assign done       = (r_state == S_HALT);
    assign halt_cause = r_cause;

endmodule

// File: tb/tb_hack_run_controller.sv
// Scoreboard bench for hack_run_controller with a stand-in CPU that runs a linear program.
module tb_hack_run_controller;
    import hack_run_pkg::*;

    localparam int CNT_W        = 16;
    localparam int PC_W         = 15;
    localparam int RESET_CYCLES = 4;

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             step = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] run_len = '0;
    logic             bp_en = 1'b0;
    logic [PC_W-1:0]  bp_addr = '0;
    logic [PC_W-1:0]  pc = '0;
    logic             cpu_reset, cpu_ce, busy, done;
    logic [CNT_W-1:0] cycle_count;
    logic [1:0]       halt_cause;

    hack_run_controller #(
        .CNT_W(CNT_W), .PC_W(PC_W), .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .CLK(CLK), .reset(reset), .start(start), .step(step), .stop(stop),
        .mode(mode), .run_len(run_len), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_reset(cpu_reset), .cpu_ce(cpu_ce), .busy(busy), .done(done),
        .cycle_count(cycle_count), .halt_cause(halt_cause)
    );

    always #5 CLK = ~CLK;

    // Stand-in Computer: synchronous reset to 0, otherwise one instruction per enabled edge.
    always @(posedge CLK) begin
        if (cpu_ce) pc <= cpu_reset ? '0 : pc + PC_W'(1);
    end

    typedef struct {
        int cause;
        int cycles;
        int total;
        int pc;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad = 0;
    int              m_total = 0;
    logic [PC_W-1:0] m_pc = '0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: counts executed cycles and scores each entry into HALT.
    initial begin
        int   ce_run;
        logic prev_done;
        exp_t e;
        ce_run    = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (reset || cpu_reset) ce_run = 0;
            else if (cpu_ce && busy) ce_run++;
            if (done && !prev_done) begin
                chk("sb_pending", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("halt_cause", int'(halt_cause), e.cause);
                    chk("ce_cycles", ce_run, e.cycles);
                    chk("cycle_count", int'(cycle_count), e.total);
                    chk("pc", int'(pc), e.pc);
                end
                ce_run = 0;
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; tick(); step = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic expect_halt(input int cause, input int cycles);
        exp_t e;
        m_total = (m_total + cycles > 65535) ? 65535 : m_total + cycles;
        m_pc    = m_pc + PC_W'(cycles);
        e.cause  = cause;
        e.cycles = cycles;
        e.total  = m_total;
        e.pc     = int'(m_pc);
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_reached_halt"}, int'(done), 1);
        tick();
    endtask

    // Asserts reset without a clock edge, checks the reset image, then measures the hold.
    task automatic reset_seq(input string name);
        int n;
        reset = 1'b1;
        #1;
        chk({name, "_cpu_reset"}, int'(cpu_reset), 1);
        chk({name, "_cpu_ce"}, int'(cpu_ce), 1);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_count"}, int'(cycle_count), 0);
        chk({name, "_cause"}, int'(halt_cause), 0);
        #100;
        @(posedge CLK); #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!cpu_reset) break;
            n++;
        end
        chk({name, "_hold_edges"}, n, RESET_CYCLES);
        chk({name, "_idle_ce"}, int'(cpu_ce), 0);
        chk({name, "_idle_count"}, int'(cycle_count), 0);
        chk({name, "_idle_busy"}, int'(busy), 0);
        @(posedge CLK); #1;
        m_pc    = '0;
        m_total = 0;
        sb.delete();
    endtask

    task automatic run_counted(input int n);
        logic [PC_W-1:0] dd;
        int d;
        dd = bp_addr - m_pc;
        d  = int'(dd);
        mode    = MODE_COUNT;
        run_len = CNT_W'(n);
        if (bp_en && d != 0 && d < n) expect_halt(int'(CAUSE_BP), d);
        else expect_halt(int'(CAUSE_COUNT), n);
        pulse_start();
        wait_done("counted");
    endtask

    task automatic run_free_bp(input int d);
        mode    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        bp_en   = 1'b1;
        bp_addr = m_pc + PC_W'(d);
        expect_halt(int'(CAUSE_BP), d);
        pulse_start();
        wait_done("free_bp");
    endtask

    // Stop lands in the k-th run cycle; with collide the breakpoint hits that same cycle.
    task automatic run_free_stop(input int k, input bit collide);
        mode = MODE_FREE;
        if (collide) begin
            bp_en   = 1'b1;
            bp_addr = m_pc + PC_W'(k - 1);
            expect_halt(int'(CAUSE_STOP), k - 1);
        end else begin
            bp_en = 1'b0;
            expect_halt(int'(CAUSE_STOP), k);
        end
        pulse_start();
        repeat (k - 1) tick();
        pulse_stop();
        wait_done("free_stop");
    endtask

    task automatic run_steps(input int nsteps);
        mode  = MODE_STEP;
        bp_en = 1'b0;
        expect_halt(int'(CAUSE_STOP), nsteps);
        pulse_start();
        for (int i = 0; i < nsteps; i++) begin
            pulse_step();
            if (i == 0) pulse_step();
            repeat (4) tick();
        end
        pulse_stop();
        wait_done("step");
    endtask

    initial begin
        #2;
        reset_seq("por");

        run_counted(30);
        run_counted(5);

        mode  = MODE_FREE;
        bp_en = 1'b0;
        pulse_start();
        repeat (7) tick();
        reset_seq("midrun");

        bp_en   = 1'b1;
        bp_addr = PC_W'(10);
        mode    = MODE_FREE;
        expect_halt(int'(CAUSE_BP), 10);
        pulse_start();
        wait_done("bp10");
        run_counted(5);

        run_steps(3);
        run_free_stop(6, 1'b1);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    bp_en   = ($urandom_range(0, 1) == 1);
                    bp_addr = m_pc + PC_W'($urandom_range(0, 50));
                    run_counted($urandom_range(1, 40));
                end
                1: run_free_bp($urandom_range(1, 40));
                2: run_free_stop($urandom_range(1, 30), 1'b0);
                3: run_free_stop($urandom_range(2, 30), 1'b1);
                default: run_steps($urandom_range(1, 4));
            endcase
        end

        reset_seq("final");
        mode    = MODE_COUNT;
        run_len = '0;
        expect_halt(int'(CAUSE_COUNT), 0);
        pulse_start();
        wait_done("zero_len");
        repeat (2) tick();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
